// File: rtl/instr_register_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : instr_register_pkg
//  Description : Shared types for the instruction register and the execution
//                stage: opcode encoding, operand, result and address types.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_register_pkg;

  // Encodings 8..15 are deliberately unassigned; the execution stage flags
  // them as illegal.
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] operand_res;
  typedef logic        [4:0]  address_t;

endpackage
`default_nettype wire

// File: rtl/instr_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_exec_unit
//  Description : Execution stage behind the instruction register. Computes a
//                64-bit signed result per instruction and hands it to
//                write-back over a valid/ready handshake. ZERO/PASSA/PASSB/
//                ADD/SUB/MULT complete in one cycle; DIV/MOD use an iterative
//                restoring divider on operand magnitudes.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk            clock, rising edge
//    reset_n        synchronous active-low reset
//    in_valid/ready upstream handshake; in_addr, in_opc, in_op_a, in_op_b
//                   are captured on the accepting edge
//    out_valid/ready downstream handshake for the result
//    out_addr/opc   address and opcode of the completed instruction
//    out_result     64-bit signed result
//    out_div_zero   DIV/MOD issued with a zero divisor
//    out_illegal    opcode in the range 8..15
//    instr_count    number of completed output handshakes (wraps)
// ============================================================================
module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int DIV_BITS_PER_CYCLE = 1   // 1, 2 or 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  address_t    in_addr,
  input  opcode_t     in_opc,
  input  operand_t    in_op_a,
  input  operand_t    in_op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output address_t    out_addr,
  output opcode_t     out_opc,
  output operand_res  out_result,
  output logic        out_div_zero,
  output logic        out_illegal,
  output logic [15:0] instr_count
);

  localparam int            ITERS      = 32 / DIV_BITS_PER_CYCLE;
  localparam int            CW         = $clog2(ITERS);
  localparam logic [CW-1:0] ITER_FIRST = CW'(ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] dvd_q;     // dividend shifts out the top, quotient shifts in
  logic [31:0] rem_q;     // partial remainder
  logic [31:0] dsr_q;     // divisor magnitude
  logic        qneg_q;    // quotient must be negated
  logic        rneg_q;    // remainder must be negated (dividend sign)
  logic        mod_q;     // remainder requested instead of quotient
  address_t    addr_q;
  opcode_t     opc_q;

  logic        out_valid_q;
  operand_res  out_result_q;
  address_t    out_addr_q;
  opcode_t     out_opc_q;
  logic        out_div_zero_q;
  logic        out_illegal_q;
  logic [15:0] count_q;

  // --------------------------------------------------------------------------
  // Accept logic and single-cycle datapath
  // --------------------------------------------------------------------------
  logic        w_in_ready;
  logic        w_accept;
  logic        w_is_div;
  logic        w_b_zero;
  logic        w_div_start;
  operand_res  w_a64;
  operand_res  w_b64;
  operand_res  w_result;
  logic [31:0] w_a_u;
  logic [31:0] w_b_u;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;

  assign w_in_ready  = reset_n &&
                       ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign w_accept    = in_valid && w_in_ready;
  assign w_is_div    = (in_opc == DIV) || (in_opc == MOD);
  assign w_b_zero    = (in_op_b == '0);
  assign w_div_start = w_is_div && !w_b_zero;

  assign w_a64 = operand_res'(in_op_a);
  assign w_b64 = operand_res'(in_op_b);

  // Two's-complement magnitude; INT_MIN maps to 0x8000_0000 unsigned.
  assign w_a_u   = in_op_a;
  assign w_b_u   = in_op_b;
  assign w_a_mag = w_a_u[31] ? (~w_a_u + 32'd1) : w_a_u;
  assign w_b_mag = w_b_u[31] ? (~w_b_u + 32'd1) : w_b_u;

  // Divide-by-zero and illegal opcodes fall through to a zero result.
  always_comb begin
    w_result = '0;
    case (in_opc)
      PASSA:   w_result = w_a64;
      PASSB:   w_result = w_b64;
      ADD:     w_result = w_a64 + w_b64;
      SUB:     w_result = w_a64 - w_b64;
      MULT:    w_result = w_a64 * w_b64;
      default: w_result = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Restoring divide step: DIV_BITS_PER_CYCLE quotient bits per cycle
  // --------------------------------------------------------------------------
  logic [31:0] w_dvd_d;
  logic [31:0] w_rem_d;
  logic [32:0] w_sh;
  logic [63:0] w_q64;
  logic [63:0] w_r64;
  logic [63:0] w_div_res;

  always_comb begin
    w_dvd_d = dvd_q;
    w_rem_d = rem_q;
    w_sh    = '0;
    for (int k = 0; k < DIV_BITS_PER_CYCLE; k++) begin
      w_sh    = {w_rem_d, w_dvd_d[31]};
      w_dvd_d = {w_dvd_d[30:0], 1'b0};
      if (w_sh >= {1'b0, dsr_q}) begin
        w_sh       = w_sh - {1'b0, dsr_q};
        w_dvd_d[0] = 1'b1;
      end
      w_rem_d = w_sh[31:0];
    end
  end

  // Sign fix-up applied to the final step's output as the FSM enters DONE.
  assign w_q64     = {32'd0, w_dvd_d};
  assign w_r64     = {32'd0, w_rem_d};
  assign w_div_res = mod_q ? (rneg_q ? (~w_r64 + 64'd1) : w_r64)
                           : (qneg_q ? (~w_q64 + 64'd1) : w_q64);

  // --------------------------------------------------------------------------
  // FSM and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      dvd_q          <= '0;
      rem_q          <= '0;
      dsr_q          <= '0;
      qneg_q         <= 1'b0;
      rneg_q         <= 1'b0;
      mod_q          <= 1'b0;
      addr_q         <= '0;
      opc_q          <= ZERO;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_addr_q     <= '0;
      out_opc_q      <= ZERO;
      out_div_zero_q <= 1'b0;
      out_illegal_q  <= 1'b0;
      count_q        <= '0;
    end else begin
      // Output handshake retires the current result; a load below may
      // immediately replace it.
      if (out_valid_q && out_ready) begin
        count_q     <= count_q + 16'd1;
        out_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            if (w_div_start) begin
              state_q <= S_DIVIDE;
              cnt_q   <= ITER_FIRST;
              dvd_q   <= w_a_mag;
              rem_q   <= '0;
              dsr_q   <= w_b_mag;
              qneg_q  <= in_op_a[31] ^ in_op_b[31];
              rneg_q  <= in_op_a[31];
              mod_q   <= (in_opc == MOD);
              addr_q  <= in_addr;
              opc_q   <= in_opc;
            end else begin
              state_q        <= S_DONE;
              out_valid_q    <= 1'b1;
              out_result_q   <= w_result;
              out_addr_q     <= in_addr;
              out_opc_q      <= in_opc;
              out_div_zero_q <= w_is_div && w_b_zero;
              out_illegal_q  <= in_opc[3];
            end
          end else if ((state_q == S_DONE) && out_ready) begin
            state_q <= S_IDLE;
          end
        end

        S_DIVIDE: begin
          dvd_q <= w_dvd_d;
          rem_q <= w_rem_d;
          if (cnt_q == '0) begin
            state_q        <= S_DONE;
            out_valid_q    <= 1'b1;
            out_result_q   <= w_div_res;
            out_addr_q     <= addr_q;
            out_opc_q      <= opc_q;
            out_div_zero_q <= 1'b0;
            out_illegal_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_addr     = out_addr_q;
  assign out_opc      = out_opc_q;
  assign out_div_zero = out_div_zero_q;
  assign out_illegal  = out_illegal_q;
  assign instr_count  = count_q;

endmodule
`default_nettype wire

// File: doc/instr_exec_unit.md
# instr_exec_unit

Execution stage directly downstream of the instruction register: takes one fetched instruction (opcode, signed operands, source address), computes the 64-bit signed result and presents it with a valid/ready handshake for write-back. Single-cycle datapath for ZERO/PASSA/PASSB/ADD/SUB/MULT. Multi-cycle iterative divider for DIV/MOD. Uses the `opcode_t`, `operand_t`, `operand_res` and `address_t` types from `instr_register_pkg`.

## Interface
- DIV_BITS_PER_CYCLE, 1: quotient bits resolved per divide iteration. Legal values are 1, 2 and 4; divide iterations = 32/DIV_BITS_PER_CYCLE.
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  unit can accept an instruction this cycle.
- in_addr  in  5 (address_t)  register address the instruction was read from.
- in_opc  in  4 (opcode_t)  operation.
- in_op_a  in  32 signed (operand_t)  operand A.
- in_op_b  in  32 signed (operand_t)  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_addr  out  5  address of the completed instruction.
- out_opc  out  4  opcode of the completed instruction.
- out_result  out  64 signed (operand_res)  result.
- out_div_zero  out  1  DIV/MOD issued with op_b == 0.
- out_illegal  out  1  opcode value is 8..15.
- instr_count  out  16  completed-instruction count.

## Operation
- FSM states are IDLE, DIVIDE and DONE. The reset state is IDLE.
- Accept: an instruction is accepted when `in_valid && in_ready`. Operands, opcode and address are captured at that edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back issue is allowed while the result drains.
- Transitions:
  - IDLE → DONE on accepting a non-divide opcode.
  - IDLE → DIVIDE on accepting DIV or MOD with op_b ≠ 0.
  - DIVIDE → DONE after the last iteration.
  - DONE → IDLE on `out_ready` with no new accept.
  - DONE → DONE or DIVIDE on `out_ready` with a simultaneous accept.
  - DONE holds while out_ready is 0.
- Arithmetic: operands are sign-extended to 64 bits before the operation. The result never overflows.
  - ZERO → 0.
  - PASSA → a.
  - PASSB → b.
  - ADD → a+b.
  - SUB → a−b.
  - MULT → full 64-bit signed product.
  - DIV → quotient truncated toward zero.
  - MOD → remainder carrying the sign of the dividend, so that a == q*b + r.
- Divider: restoring division on unsigned magnitudes. |INT_MIN| = 2^31 fits in 32 unsigned bits. Signs are fixed up when entering DONE.
  - INT_MIN / −1 → +2147483648.
  - INT_MIN % −1 → 0.
- Divide by zero: DIV/MOD with b==0 goes straight to DONE with result 0 and out_div_zero=1. No iterations.
- Illegal opcode (8..15): goes to DONE with result 0 and out_illegal=1.
- Flags are valid only with out_valid. Each flag is cleared for every new instruction.
- instr_count increments once per output handshake (`out_valid && out_ready`). It wraps 0xFFFF → 0x0000.

## Timing
- Reset: any edge with reset_n=0 sets the following values:
  - state = IDLE.
  - in_ready = 1 once reset is released. in_ready is held 0 while reset_n=0.
  - out_valid = 0, out_result = 0, out_addr = 0, out_opc = ZERO.
  - out_div_zero = 0, out_illegal = 0, instr_count = 0.
- Reset mid-DIVIDE or mid-DONE abandons the instruction. Nothing is counted.
- Single-cycle ops: out_valid rises the cycle after the accept edge (latency 1). Throughput is 1 per cycle while out_ready=1.
- DIV/MOD: out_valid rises 1 + 32/DIV_BITS_PER_CYCLE cycles after the accept edge. With the default parameter that is 33.
- in_ready is 0 throughout DIVIDE.
- Backpressure: while out_valid=1 and out_ready=0, all out_* signals are held stable.
- out_valid drops the cycle after the handshake, unless a new result is loaded at that same edge.

## Test plan
- Reset then ADD: drive reset_n low 2 cycles, then issue ADD a=0x7FFFFFFF, b=1, addr 3 → next cycle out_valid=1, out_result=0x0000_0000_8000_0000, out_addr=3, instr_count goes 0→1 on the handshake.
- MULT and SUB signedness: MULT a=−3, b=7 → −21. SUB a=INT_MIN, b=1 → −2147483649. Both have latency 1. Issue them back-to-back with out_ready=1 and check no bubble.
- DIV/MOD: DIV −7/2 → −3 and MOD −7%2 → −1, each out_valid exactly 33 cycles after accept. Separately, INT_MIN/−1 → 2147483648. Repeat with DIV_BITS_PER_CYCLE=4 and check latency 9.
- Exceptions: DIV 5/0 → result 0, out_div_zero=1, latency 1. Opcode 4'hC → result 0, out_illegal=1. The next ADD clears both flags.
- Backpressure: hold out_ready=0 for 5 cycles after a result → outputs stable, in_ready=0. Then raise out_ready with in_valid=1 → accept and drain at the same edge.
- Reset mid-divide and wrap: assert reset_n=0 at cycle 10 of a DIV → out_valid never rises, state IDLE. Separately, 65536 handshakes → instr_count wraps back to 0.
